// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: requester limit, RAM read
// latency and the tag that follows each accepted command down the pipeline.
package ram_arb_pkg;

  localparam int MAX_REQ          = 8;
  localparam int RAM_READ_LATENCY = 1;
  localparam int ID_WIDTH         = $clog2(MAX_REQ);

  // Travels alongside a command so read data can be steered back to its owner.
  typedef struct packed {
    logic                is_read;
    logic [ID_WIDTH-1:0] id;
  } req_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Requester picker: scans the pending vector starting at 'start' (wrapping at
// NUM_REQ) and grants the first pending requester. A start of 0 gives plain
// fixed priority, lowest index first.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]  pending,
  input  logic [ID_WIDTH-1:0] start,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] index,
  output logic                any
);

  // Wrapping priority scan; the first pending candidate wins.
  always_comb begin
    int cand;
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(start) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && pending[cand]) begin
        any         = 1'b1;
        index       = ID_WIDTH'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter for NUM_REQ clients (CPU/DMA/video style).
// Optional macro RAM_ARB_ROUND_ROBIN_EN: round-robin arbitration with a
// rotating start pointer; without it, fixed priority (lowest index wins).
//
// Handshake: a requester raises rd and/or wr (rd+wr counts as a write) with
// addr/mask/din and holds them until io_req_ack[i] is seen high in the same
// cycle; it may change or drop the request in the following cycle. The command
// appears on io_ram_* one cycle after the ack. For reads, io_req_valid[i]
// pulses for one cycle two cycles after the ack with io_req_dout qualified by
// it; writes produce no response, the ack marks completion.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  io_req_rd,
  input  logic [NUM_REQ-1:0]                  io_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       io_req_addr,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   io_req_mask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       io_req_din,
  output logic [NUM_REQ-1:0]                  io_req_ack,
  output logic [NUM_REQ-1:0]                  io_req_valid,
  output logic [DATA_WIDTH-1:0]               io_req_dout,
  output logic                                io_ram_rd,
  output logic                                io_ram_wr,
  output logic [ADDR_WIDTH-1:0]               io_ram_addr,
  output logic [(DATA_WIDTH/8)-1:0]           io_ram_mask,
  output logic [DATA_WIDTH-1:0]               io_ram_din,
  input  logic [DATA_WIDTH-1:0]               io_ram_dout
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  // One stage for the command register plus the RAM's own read latency.
  localparam int TAG_STAGES = RAM_READ_LATENCY + 1;

  logic [NUM_REQ-1:0]    pending;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  win_any;
  logic                  win_rd;
  logic                  win_wr;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [MASK_WIDTH-1:0] sel_mask;
  logic [DATA_WIDTH-1:0] sel_din;
  logic [DATA_WIDTH-1:0] dout_hold;
  req_tag_t              tag_q [TAG_STAGES];
  req_tag_t              tag_out;

  assign pending = io_req_rd | io_req_wr;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Rotate the search start to just past the last winner so nobody starves.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (win_any) begin
      rr_ptr <= (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .pending (pending),
    .start   (rr_ptr),
    .grant   (grant),
    .index   (win_idx),
    .any     (win_any)
  );

  assign io_req_ack = grant;
  // A request carrying both rd and wr is treated as a write only.
  assign win_wr     = |(grant & io_req_wr);
  assign win_rd     = |(grant & io_req_rd) & ~win_wr;

  // Route the granted requester's command fields to the RAM command register.
  always_comb begin
    sel_addr = '0;
    sel_mask = '0;
    sel_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = io_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_mask = io_req_mask[i*MASK_WIDTH +: MASK_WIDTH];
        sel_din  = io_req_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // RAM command register: strobes pulse per grant, payload holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_ram_rd   <= 1'b0;
      io_ram_wr   <= 1'b0;
      io_ram_addr <= '0;
      io_ram_mask <= '0;
      io_ram_din  <= '0;
    end else begin
      io_ram_rd <= win_rd;
      io_ram_wr <= win_wr;
      if (win_any) begin
        io_ram_addr <= sel_addr;
        io_ram_mask <= sel_mask;
        io_ram_din  <= sel_din;
      end
    end
  end

  // Tag pipeline tracking which requester owns the data returning from RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < TAG_STAGES; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{is_read: win_rd, id: win_idx};
      for (int s = 1; s < TAG_STAGES; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign tag_out = tag_q[TAG_STAGES-1];

  // Decode the final tag stage into a one-hot read-valid pulse.
  always_comb begin
    io_req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_out.is_read && (tag_out.id == ID_WIDTH'(i))) io_req_valid[i] = 1'b1;
    end
  end

  // Read data passes straight through when valid; otherwise the last value holds.
  assign io_req_dout = tag_out.is_read ? io_ram_dout : dout_hold;

  // Capture the shared bus so it can hold between read responses.
  always_ff @(posedge clock) begin
    if (reset) dout_hold <= '0;
    else       dout_hold <= io_req_dout;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with three requesters and a behavioural RAM.
// Honours RAM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_ram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 15;
  localparam int DW   = 16;
  localparam int MW   = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_rd   = '0;
  logic [NREQ-1:0]    req_wr   = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*MW-1:0] req_mask = '0;
  logic [NREQ*DW-1:0] req_din  = '0;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    valid;
  logic [DW-1:0]      dout;
  logic               ram_rd;
  logic               ram_wr;
  logic [AW-1:0]      ram_addr;
  logic [MW-1:0]      ram_mask;
  logic [DW-1:0]      ram_din;
  logic [DW-1:0]      ram_dout;

  ram_port_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock        (clk),
    .reset        (rst),
    .io_req_rd    (req_rd),
    .io_req_wr    (req_wr),
    .io_req_addr  (req_addr),
    .io_req_mask  (req_mask),
    .io_req_din   (req_din),
    .io_req_ack   (ack),
    .io_req_valid (valid),
    .io_req_dout  (dout),
    .io_ram_rd    (ram_rd),
    .io_ram_wr    (ram_wr),
    .io_ram_addr  (ram_addr),
    .io_ram_mask  (ram_mask),
    .io_ram_din   (ram_din),
    .io_ram_dout  (ram_dout)
  );

  // ---------------- RAM model: registered read, byte-masked write ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < MW; b++) if (ram_mask[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int            due_q [$];
  int            id_q  [$];
  int            ptr;
  int            cyc;
  int            win;
  logic          exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [MW-1:0] exp_mask;
  logic [DW-1:0] exp_din;
  logic [DW-1:0] last_dout;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Arbitration rule: first pending requester searching upward from ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] pend);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ptr + k) % NREQ;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr = 0;
    exp_q.delete();
    due_q.delete();
    id_q.delete();
    exp_rd = 1'b0; exp_wr = 1'b0;
    exp_addr = '0; exp_mask = '0; exp_din = '0;
    last_dout = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
    req_rd[r] = rd;
    req_wr[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_mask[r*MW +: MW] = m;
    req_din[r*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    req_rd = '0;
    req_wr = '0;
  endtask

  // One clock cycle: called just after a rising edge with inputs already set.
  task automatic step();
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] e_ack;
    logic [NREQ-1:0] e_valid;
    logic [DW-1:0]   e_dout;
    logic [AW-1:0]   a;
    logic [MW-1:0]   m;
    logic [DW-1:0]   d;
    int              w;
    #1;
    pend  = req_rd | req_wr;
    w     = pick(pend);
    e_ack = (w < 0) ? '0 : NREQ'(1 << w);
    check("ack", 32'(ack), 32'(e_ack));
    e_valid = '0;
    e_dout  = last_dout;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e_valid   = NREQ'(1 << id_q[0]);
      e_dout    = exp_q[0];
      last_dout = exp_q[0];
      void'(due_q.pop_front());
      void'(id_q.pop_front());
      void'(exp_q.pop_front());
    end
    check("valid", 32'(valid), 32'(e_valid));
    check("dout", 32'(dout), 32'(e_dout));
    check("ram_rd", 32'(ram_rd), 32'(exp_rd));
    check("ram_wr", 32'(ram_wr), 32'(exp_wr));
    check("ram_addr", 32'(ram_addr), 32'(exp_addr));
    check("ram_mask", 32'(ram_mask), 32'(exp_mask));
    check("ram_din", 32'(ram_din), 32'(exp_din));
    win    = w;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      m = req_mask[w*MW +: MW];
      d = req_din[w*DW +: DW];
      exp_addr = a; exp_mask = m; exp_din = d;
      if (req_wr[w]) begin
        exp_wr = 1'b1;
        for (int b = 0; b < MW; b++) if (m[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        exp_rd = 1'b1;
        due_q.push_back(cyc + 2);
        id_q.push_back(w);
        exp_q.push_back(shadow[a]);
      end
`ifdef RAM_ARB_ROUND_ROBIN_EN
      ptr = (w + 1) % NREQ;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0]   pool [8];
  logic [NREQ-1:0] t4_seq [4];

  initial begin
    pool = '{15'h0000, 15'h7FFF, 15'h1234, 15'h0010, 15'h0001, 15'h2AAA, 15'h5555, 15'h4000};
`ifdef RAM_ARB_ROUND_ROBIN_EN
    t4_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
`else
    t4_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    model_reset();
    cyc = 0;
    win = -1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_ram_rd", 32'(ram_rd), 0);
    check("rst_ram_wr", 32'(ram_wr), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while a read is in flight: its response must never appear
    set_req(0, 1'b1, 1'b0, 15'h0100, 2'b11, 16'h0000);
    step();
    clear_reqs();
    rst = 1'b1;
    #1;
    check("t1_ram_rd_c1", 32'(ram_rd), 1);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    check("t1_valid_c2", 32'(valid), 0);
    check("t1_dout_c2", 32'(dout), 0);
    check("t1_ram_rd_c2", 32'(ram_rd), 0);
    check("t1_ram_addr_c2", 32'(ram_addr), 0);
    check("t1_ram_mask_c2", 32'(ram_mask), 0);
    model_reset();
    repeat (3) step();

    // Preload through the arbiter
    set_req(0, 1'b0, 1'b1, 15'h1234, 2'b11, 16'hBEEF); step();
    set_req(0, 1'b0, 1'b1, 15'h0010, 2'b11, 16'h1111); step();
    clear_reqs(); step();

    // Single read by requester 1
    set_req(1, 1'b1, 1'b0, 15'h1234, 2'b00, 16'h0000); step();
    clear_reqs(); step();
    #1;
    check("t2_valid", 32'(valid), 32'(3'b010));
    check("t2_dout", 32'(dout), 32'h0000BEEF);
    step(); step();

    // Low-byte masked write, then read back
    set_req(0, 1'b0, 1'b1, 15'h0010, 2'b01, 16'hAA55); step();
    set_req(0, 1'b1, 1'b0, 15'h0010, 2'b00, 16'h0000); step();
    clear_reqs(); step();
    #1;
    check("t3_valid", 32'(valid), 32'(3'b001));
    check("t3_dout", 32'(dout), 32'h00001155);
    step(); step();

    // Contention between requesters 0 and 1
    set_req(0, 1'b1, 1'b0, 15'h1234, 2'b00, 16'h0000);
    set_req(1, 1'b1, 1'b0, 15'h0010, 2'b00, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_ack_seq", 32'(ack), 32'(t4_seq[k]));
      step();
    end
    req_rd[0] = 1'b0;
    #1;
    check("t5_ack_after_drop", 32'(ack), 32'(3'b010));
    step();
    clear_reqs();
    repeat (3) step();

    // Write then read of the same address on consecutive cycles
    set_req(0, 1'b0, 1'b1, 15'h7FFF, 2'b11, 16'h5A5A); step();
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 15'h7FFF, 2'b00, 16'h0000); step();
    clear_reqs(); step();
    #1;
    check("t6_valid", 32'(valid), 32'(3'b010));
    check("t6_dout", 32'(dout), 32'h00005A5A);
    step(); step();

    // Initialise the random address pool with known data
    for (int p = 0; p < 8; p++) begin
      set_req(2, 1'b0, 1'b1, pool[p], 2'b11, 16'($urandom));
      step();
    end
    clear_reqs();

    // Random traffic; each requester holds its request until acked
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!(req_rd[r] | req_wr[r]) && $urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 3))
            0, 1: set_req(r, 1'b1, 1'b0, pool[$urandom_range(0, 7)], 2'($urandom), 16'($urandom));
            2:    set_req(r, 1'b0, 1'b1, pool[$urandom_range(0, 7)], 2'($urandom), 16'($urandom));
            default: set_req(r, 1'b1, 1'b1, pool[$urandom_range(0, 7)], 2'($urandom), 16'($urandom));
          endcase
        end
      end
      step();
      if (win >= 0) begin
        req_rd[win] = 1'b0;
        req_wr[win] = 1'b0;
      end
    end
    clear_reqs();
    repeat (4) step();
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
